// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
//   mem_state_t  : INIT (zero-fill sweep) / RUN
//   wbuf_entry_t : posted-store entry at the default widths
//   DEPTH        : default word count of the array
package pipelined_mem_pkg;
    localparam int DATA_SIZE_D = 32;
    localparam int ADDR_SIZE_D = 10;
    localparam int DEPTH       = 2 ** ADDR_SIZE_D;

    typedef enum logic {MEM_INIT, MEM_RUN} mem_state_t;

    typedef struct packed {
        logic [ADDR_SIZE_D-1:0] addr;
        logic [DATA_SIZE_D-1:0] data;
    } wbuf_entry_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side data-memory bus plus the preload port.
//   master : core / bench side, drives requests, sees load data and ready flags
//   slave  : responder side
interface data_mem_responder_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
);
    logic [ADDR_SIZE-1:0] daddr;
    logic [DATA_SIZE-1:0] ddata_w;
    logic                 mem_write;
    logic                 mem_read;
    logic [DATA_SIZE-1:0] ddata_r;
    logic                 mem_ready;
    logic                 pl_valid;
    logic [ADDR_SIZE-1:0] pl_addr;
    logic [DATA_SIZE-1:0] pl_data;
    logic                 pl_ready;

    modport master (
        output daddr, ddata_w, mem_write, mem_read, pl_valid, pl_addr, pl_data,
        input  ddata_r, mem_ready, pl_ready
    );
    modport slave (
        input  daddr, ddata_w, mem_write, mem_read, pl_valid, pl_addr, pl_data,
        output ddata_r, mem_ready, pl_ready
    );
endinterface

// File: rtl/data_mem_responder_wbuf_fifo.sv
// Posted-store circular FIFO with a combinational youngest-match lookup.
//   clk, rst_n           : clock, synchronous active-low reset (empties the FIFO)
//   push/push_addr/data  : enqueue (caller guarantees !full or a same-cycle pop)
//   pop                  : dequeue head (caller guarantees !empty)
//   full, empty          : occupancy flags
//   head_addr/head_data  : oldest entry, written to the array on drain
//   lk_addr/lk_hit/lk_data : youngest valid entry whose address matches lk_addr
module wbuf_fifo #(
    parameter int ADDR_SIZE  = 10,
    parameter int DATA_SIZE  = 32,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [ADDR_SIZE-1:0] push_addr,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE-1:0] head_addr,
    output logic [DATA_SIZE-1:0] head_data,
    input  logic [ADDR_SIZE-1:0] lk_addr,
    output logic                 lk_hit,
    output logic [DATA_SIZE-1:0] lk_data
);
    localparam int PW = $clog2(WBUF_DEPTH);

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] data;
    } entry_t;

    entry_t        slots [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, idx;
    logic [PW:0]   count;

    assign full      = (count == (PW+1)'(WBUF_DEPTH));
    assign empty     = (count == '0);
    assign head_addr = slots[rd_ptr].addr;
    assign head_data = slots[rd_ptr].data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= '{addr: push_addr, data: push_data};
    end

    // Walk oldest -> youngest so the last match left standing is the youngest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count && slots[idx].addr == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = slots[idx].data;
            end
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a posted-store buffer with read bypass,
// zero-fill sweep after reset, and a preload port sharing the single write port.
//   CLK, RESET_N : clock, synchronous active-low reset
//   bus          : core load/store bus + preload port (slave side)
//   wbuf_ovf     : sticky, a store was dropped on a full buffer
//   rd_count     : accepted loads, saturating
//   wr_count     : accepted stores, saturating
module data_mem_responder
    import pipelined_mem_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 10,
    parameter int WBUF_DEPTH = 2,
    parameter int CNT_SIZE   = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    data_mem_responder_if.slave bus,
    output logic                wbuf_ovf,
    output logic [CNT_SIZE-1:0] rd_count,
    output logic [CNT_SIZE-1:0] wr_count
);
    localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

    mem_state_t           state, state_nxt;
    logic [ADDR_SIZE-1:0] sweep_ptr;
    logic [DATA_SIZE-1:0] array [MEM_DEPTH];

    logic                 full, empty, drain, push, drop;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [DATA_SIZE-1:0] head_data, lk_data;
    logic                 lk_hit;

    logic                 we;
    logic [ADDR_SIZE-1:0] waddr;
    logic [DATA_SIZE-1:0] wdata;

    // FSM: INIT sweeps every word once, then RUN until reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= MEM_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_ready = 1'b0;
        bus.pl_ready  = 1'b0;
        drain         = 1'b0;
        case (state)
            MEM_INIT: if (&sweep_ptr) state_nxt = MEM_RUN;
            MEM_RUN: begin
                bus.mem_ready = 1'b1;
                bus.pl_ready  = bus.pl_valid;
                drain         = !empty && !bus.pl_valid;
            end
            default: state_nxt = MEM_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)              sweep_ptr <= '0;
        else if (state == MEM_INIT) sweep_ptr <= sweep_ptr + 1'b1;
    end

    // A full buffer still accepts a store when its head drains the same cycle.
    assign push = bus.mem_write && (!full || drain);
    assign drop = bus.mem_write && full && !drain;

    wbuf_fifo #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .WBUF_DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .push     (push),
        .push_addr(bus.daddr),
        .push_data(bus.ddata_w),
        .pop      (drain),
        .full     (full),
        .empty    (empty),
        .head_addr(head_addr),
        .head_data(head_data),
        .lk_addr  (bus.daddr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
    );

    // Single write port: sweep > preload > drain.
    always_comb begin
        we    = 1'b0;
        waddr = head_addr;
        wdata = head_data;
        if (state == MEM_INIT) begin
            we    = 1'b1;
            waddr = sweep_ptr;
            wdata = '0;
        end else if (bus.pl_ready) begin
            we    = 1'b1;
            waddr = bus.pl_addr;
            wdata = bus.pl_data;
        end else if (drain) begin
            we    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) array[waddr] <= wdata;
    end

    // A store enqueues at the edge, so a same-cycle load still sees the old value.
    assign bus.ddata_r = (state == MEM_INIT)         ? '0      :
                         (bus.mem_read && lk_hit)    ? lk_data :
                                                       array[bus.daddr];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wbuf_ovf <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (drop) wbuf_ovf <= 1'b1;
            if (bus.mem_read && !(&rd_count)) rd_count <= rd_count + 1'b1;
            if (push && !(&wr_count))         wr_count <= wr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int WB    = 2;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          wbuf_ovf;
    logic [CW-1:0] rd_count, wr_count;

    int checks = 0;
    int errors = 0;

    data_mem_responder_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    data_mem_responder #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .WBUF_DEPTH(WB), .CNT_SIZE(CW)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave),
        .wbuf_ovf(wbuf_ovf),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain memory image, store queue, flags and counts.
    typedef struct {
        int unsigned addr;
        logic [DW-1:0] data;
    } ent_t;

    logic [DW-1:0] m_mem [DEPTH];
    ent_t          m_q[$];
    bit            m_run;
    int            m_swept;
    bit            m_ovf;
    int            m_rd, m_wr;

    function automatic logic [DW-1:0] m_read(int unsigned a);
        if (!m_run) return '0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].addr == a) return m_q[i].data;
        return m_mem[a];
    endfunction

    task automatic model_step();
        bit drain, accept;
        if (!RESET_N) begin
            m_run = 0; m_swept = 0; m_q.delete(); m_ovf = 0; m_rd = 0; m_wr = 0;
            return;
        end
        drain  = m_run && !bus.pl_valid && m_q.size() > 0;
        accept = bus.mem_write && (m_q.size() < WB || drain);
        if (!m_run) begin
            m_mem[m_swept] = '0;
            m_swept++;
            if (m_swept == DEPTH) m_run = 1;
        end else if (bus.pl_valid) begin
            m_mem[bus.pl_addr] = bus.pl_data;
        end else if (drain) begin
            m_mem[m_q[0].addr] = m_q[0].data;
            void'(m_q.pop_front());
        end
        if (accept) m_q.push_back('{addr: bus.daddr, data: bus.ddata_w});
        else if (bus.mem_write) m_ovf = 1;
        if (bus.mem_read && m_rd < CMAX) m_rd++;
        if (accept && m_wr < CMAX) m_wr++;
    endtask

    task automatic tick();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        bus.daddr = '0; bus.ddata_w = '0; bus.mem_write = 0; bus.mem_read = 0;
        bus.pl_valid = 0; bus.pl_addr = '0; bus.pl_data = '0;
    endtask

    task automatic test_reset();
        set_idle();
        RESET_N = 0;
        bus.pl_valid = 1;
        tick(); tick();
        #1;
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", bus.mem_ready); end
        checks++; if (bus.pl_ready !== 1'b0) begin errors++; $display("FAIL reset_pl_ready got %0b exp 0", bus.pl_ready); end
        checks++; if (wbuf_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", wbuf_ovf); end
        checks++; if (rd_count !== 0 || wr_count !== 0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", rd_count, wr_count); end
        bus.pl_valid = 0;
    endtask

    // Counts cycles until mem_ready; loads during the sweep must read zero.
    task automatic run_sweep(input string tag, input bit do_reads);
        int cyc = 0;
        RESET_N = 1;
        while (cyc < 2000) begin
            bus.mem_read = do_reads ? 1'($urandom) : 1'b0;
            bus.daddr    = AW'($urandom);
            #1;
            checks++; if (bus.mem_ready !== m_run) begin errors++; $display("FAIL %s_ready cyc %0d got %0b exp %0b", tag, cyc, bus.mem_ready, m_run); end
            if (bus.mem_ready === 1'b1) break;
            if (bus.mem_read) begin
                checks++; if (bus.ddata_r !== m_read(bus.daddr)) begin errors++; $display("FAIL %s_init_read got %h exp %h", tag, bus.ddata_r, m_read(bus.daddr)); end
            end
            tick();
            cyc++;
        end
        checks++; if (cyc !== DEPTH) begin errors++; $display("FAIL %s_init_len got %0d exp %0d", tag, cyc, DEPTH); end
        bus.mem_read = 0;
    endtask

    task automatic test_init();
        run_sweep("init", 1);
        for (int i = 0; i < 8; i++) begin
            bus.mem_read = 1; bus.daddr = AW'($urandom);
            #1;
            checks++; if (bus.ddata_r !== 32'h0) begin errors++; $display("FAIL zero_read @%0d got %h exp 0", bus.daddr, bus.ddata_r); end
            tick();
        end
        bus.mem_read = 0;
    endtask

    task automatic test_store_load();
        set_idle();
        bus.mem_write = 1; bus.daddr = 5; bus.ddata_w = 32'hDEADBEEF;
        tick();
        set_idle();
        bus.mem_read = 1; bus.daddr = 5;
        #1;
        checks++; if (bus.ddata_r !== 32'hDEADBEEF) begin errors++; $display("FAIL store_load got %h exp deadbeef", bus.ddata_r); end
        tick();
        set_idle();
        checks++; if (wr_count !== CW'(m_wr) || rd_count !== CW'(m_rd)) begin errors++; $display("FAIL counts got %0d/%0d exp %0d/%0d", wr_count, rd_count, m_wr, m_rd); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] pl_d = $urandom;
        set_idle(); tick(); tick();
        bus.pl_valid = 1; bus.pl_addr = 100; bus.pl_data = pl_d;
        bus.mem_write = 1; bus.daddr = 7; bus.ddata_w = 32'h11;
        #1;
        checks++; if (bus.pl_ready !== 1'b1) begin errors++; $display("FAIL pl_ready got %0b exp 1", bus.pl_ready); end
        tick();
        bus.daddr = 8; bus.ddata_w = 32'h22;
        tick();
        bus.daddr = 9; bus.ddata_w = 32'h33;
        #1;
        checks++; if (wbuf_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b exp 0", wbuf_ovf); end
        tick();
        bus.mem_write = 0;
        #1;
        checks++; if (wbuf_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", wbuf_ovf); end
        tick();
        set_idle(); tick(); tick();
        bus.mem_read = 1;
        for (int i = 0; i < 4; i++) begin
            bus.daddr = (i == 3) ? AW'(100) : AW'(7 + i);
            #1;
            checks++; if (bus.ddata_r !== m_read(bus.daddr)) begin errors++; $display("FAIL drain_read @%0d got %h exp %h", bus.daddr, bus.ddata_r, m_read(bus.daddr)); end
            tick();
        end
        checks++; if (wbuf_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", wbuf_ovf); end
        set_idle();
    endtask

    task automatic test_youngest();
        set_idle();
        bus.pl_valid = 1; bus.pl_addr = 200; bus.pl_data = $urandom;
        bus.mem_write = 1; bus.daddr = 3; bus.ddata_w = 32'hA;
        tick();
        bus.ddata_w = 32'hB;
        tick();
        bus.mem_write = 0; bus.mem_read = 1;
        #1;
        checks++; if (bus.ddata_r !== 32'hB) begin errors++; $display("FAIL youngest got %h exp b", bus.ddata_r); end
        tick();
        set_idle(); tick(); tick();
    endtask

    task automatic test_same_cycle();
        set_idle();
        bus.mem_write = 1; bus.mem_read = 1; bus.daddr = 9; bus.ddata_w = 32'h55;
        #1;
        checks++; if (bus.ddata_r !== 32'h0) begin errors++; $display("FAIL same_cycle_old got %h exp 0", bus.ddata_r); end
        tick();
        bus.mem_write = 0;
        #1;
        checks++; if (bus.ddata_r !== 32'h55) begin errors++; $display("FAIL same_cycle_new got %h exp 55", bus.ddata_r); end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        for (int n = 0; n < 400; n++) begin
            bus.mem_read  = 1'($urandom);
            bus.mem_write = 1'($urandom);
            bus.daddr     = AW'($urandom_range(0, 7));
            bus.ddata_w   = $urandom;
            bus.pl_valid  = ($urandom_range(0, 3) == 0);
            bus.pl_addr   = AW'($urandom_range(0, 7));
            bus.pl_data   = $urandom;
            #1;
            if (bus.mem_read) begin
                exp_d = m_read(bus.daddr);
                checks++; if (bus.ddata_r !== exp_d) begin errors++; $display("FAIL rand_read n %0d @%0d got %h exp %h", n, bus.daddr, bus.ddata_r, exp_d); end
            end
            checks++; if (bus.pl_ready !== bus.pl_valid) begin errors++; $display("FAIL rand_pl_ready got %0b exp %0b", bus.pl_ready, bus.pl_valid); end
            tick();
            checks++; if (rd_count !== CW'(m_rd) || wr_count !== CW'(m_wr) || wbuf_ovf !== m_ovf) begin
                errors++; $display("FAIL rand_state rd %0d/%0d wr %0d/%0d ovf %0b/%0b", rd_count, m_rd, wr_count, m_wr, wbuf_ovf, m_ovf);
            end
        end
        checks++; if (rd_count !== 8'hFF) begin errors++; $display("FAIL rd_saturate got %0d exp 255", rd_count); end
        set_idle();
    endtask

    task automatic test_reset_mid_sweep();
        set_idle();
        RESET_N = 0; tick();
        RESET_N = 1;
        for (int i = 0; i < 300; i++) tick();
        #1;
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL mid_sweep_ready got %0b exp 0", bus.mem_ready); end
        RESET_N = 0; tick();
        run_sweep("resweep", 0);
        checks++; if (rd_count !== 0 || wr_count !== 0 || wbuf_ovf !== 1'b0) begin
            errors++; $display("FAIL resweep_state rd %0d wr %0d ovf %0b exp 0", rd_count, wr_count, wbuf_ovf);
        end
        bus.mem_read = 1; bus.daddr = 9;
        #1;
        checks++; if (bus.ddata_r !== 32'h0) begin errors++; $display("FAIL resweep_zero got %h exp 0", bus.ddata_r); end
        tick();
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_overflow();
        test_youngest();
        test_same_cycle();
        test_random();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
